// File: rtl/axi_lite_7seg_slave_if.sv
// AXI4-Lite bus bundle for the 7-segment display peripheral.
// The slave modport is the peripheral side; the master modport is the processor or BFM side.
interface axi_lite_7seg_slave_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_7seg_slave.sv
// AXI4-Lite slave with four 32-bit registers: DIGITS, CTRL, BLANK and SCRATCH.
// It scans a multiplexed common-anode 7-segment display from those registers.
module axi_lite_7seg_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned NUM_DIGITS         = 8,
  parameter int unsigned SCAN_DIV           = 50000
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  axi_lite_7seg_slave_if.slave  s_axi,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [31:0]   regs [4];
  logic [31:0]   rdata_q;
  logic          wr_en, rd_en;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic          show;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic          unused_bits;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  function automatic logic [6:0] hexmap(input logic [3:0] v);
    case (v)
      4'h0: hexmap = 7'h40;  4'h1: hexmap = 7'h79;  4'h2: hexmap = 7'h24;  4'h3: hexmap = 7'h30;
      4'h4: hexmap = 7'h19;  4'h5: hexmap = 7'h12;  4'h6: hexmap = 7'h02;  4'h7: hexmap = 7'h78;
      4'h8: hexmap = 7'h00;  4'h9: hexmap = 7'h10;  4'hA: hexmap = 7'h08;  4'hB: hexmap = 7'h03;
      4'hC: hexmap = 7'h46;  4'hD: hexmap = 7'h21;  4'hE: hexmap = 7'h06;  default: hexmap = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // The ready pulse is the single ACK state, so a write can never be taken while BVALID is held.
  always_comb begin
    wr_next = wr_state;
    wr_en   = 1'b0;
    case (wr_state)
      W_IDLE: if (s_axi.awvalid && s_axi.wvalid) wr_next = W_ACK;
      W_ACK: begin
        wr_en   = s_axi.awvalid && s_axi.wvalid;
        wr_next = wr_en ? W_RESP : W_IDLE;
      end
      W_RESP: if (s_axi.bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
    s_axi.awready = (wr_state == W_ACK);
    s_axi.wready  = (wr_state == W_ACK);
    s_axi.bvalid  = (wr_state == W_RESP);
    s_axi.bresp   = '0;
  end

  always_comb begin
    rd_next = rd_state;
    rd_en   = 1'b0;
    case (rd_state)
      R_IDLE: if (s_axi.arvalid) rd_next = R_ACK;
      R_ACK: begin
        rd_en   = s_axi.arvalid;
        rd_next = rd_en ? R_DATA : R_IDLE;
      end
      R_DATA: if (s_axi.rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
    s_axi.arready = (rd_state == R_ACK);
    s_axi.rvalid  = (rd_state == R_DATA);
    s_axi.rresp   = '0;
    s_axi.rdata   = rdata_q;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned r = 0; r < 4; r++) regs[r] <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_en) begin
        for (int unsigned b = 0; b < 4; b++)
          if (s_axi.wstrb[b]) regs[s_axi.awaddr[3:2]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
      if (rd_en) rdata_q <= regs[s_axi.araddr[3:2]];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 3'(NUM_DIGITS - 1)) ? '0 : idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    nib   = 4'(regs[0] >> {idx, 2'b00});
    show  = regs[1][0] && !regs[2][idx];
    an_d  = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (show && idx == 3'(i)) an_d[i] = 1'b0;
    seg_d = show ? hexmap(nib) : 7'h7F;
    dp_d  = show ? !regs[1][8 + 32'(idx)] : 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_7seg_slave.sv
// Directed self-checking bench for axi_lite_7seg_slave (SCAN_DIV = 4, eight digits).
module tb_axi_lite_7seg_slave;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] rd;
  logic [6:0]  hex_tbl [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  axi_lite_7seg_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi_lite_7seg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_DIGITS(8),
    .SCAN_DIV(4)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi(bus),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic seen = 1'b0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.awready) begin seen = 1'b1; break; end
    end
    check_eq("aw_accept", 32'(seen), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("bvalid", 32'(bus.bvalid), 32'd1);
    check_eq("bresp", 32'(bus.bresp), 32'd0);
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic seen = 1'b0;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.arready) begin seen = 1'b1; break; end
    end
    check_eq("ar_accept", 32'(seen), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check_eq("rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("rresp", 32'(bus.rresp), 32'd0);
    data = bus.rdata;
    @(negedge clk);
  endtask

  task automatic sync_digit0();
    logic seen7 = 1'b0;
    logic ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (an == 8'h7F) seen7 = 1'b1;
      else if (seen7 && an == 8'hFE) begin ok = 1'b1; break; end
    end
    check_eq("sync_digit0", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] loop_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] loop_data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    logic [7:0]  exp_an;
    logic        seen;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_an", 32'(an), 32'hFF);
    check_eq("rst_seg", 32'(seg), 32'h7F);
    check_eq("rst_dp", 32'(dp), 32'd1);
    check_eq("rst_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    check_eq("rst_valid", 32'({bus.bvalid, bus.rvalid}), 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      axi_write(4'(loop_addr[i]), loop_data[i], 4'hF);
      axi_read(4'(loop_addr[i]), rd);
      check_eq($sformatf("loop_%0d", i), rd, loop_data[i]);
    end

    axi_write(4'hC, 32'hFFFFFFFF, 4'hF);
    axi_write(4'hC, 32'h12345678, 4'b0101);
    axi_read(4'hC, rd);
    check_eq("strobe", rd, 32'hFF34FF78);

    // Write backpressure: first write accepted, BREADY held low, second write presented.
    bus.awaddr = 4'hC; bus.wdata = 32'h11111111; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.awready) begin seen = 1'b1; break; end
    end
    check_eq("bp_w1_accept", 32'(seen), 32'd1);
    @(negedge clk);
    bus.wdata = 32'h22222222;
    for (int n = 0; n < 10; n++) begin
      check_eq("bp_bvalid_hold", 32'({bus.bvalid, bus.awready}), 32'b10);
      @(negedge clk);
    end
    axi_read(4'hC, rd);
    check_eq("bp_read_during_b", rd, 32'h11111111);
    check_eq("bp_still_held", 32'({bus.bvalid, bus.awready}), 32'b10);
    bus.bready = 1'b1;
    @(negedge clk);
    check_eq("bp_after_b", 32'({bus.bvalid, bus.awready}), 32'b00);
    @(negedge clk);
    check_eq("bp_w2_accept", 32'(bus.awready), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("bp_w2_bvalid", 32'(bus.bvalid), 32'd1);
    @(negedge clk);
    axi_read(4'hC, rd);
    check_eq("bp_w2_data", rd, 32'h22222222);

    // Read backpressure: first read returns DIGITS, second read of CTRL waits for RREADY.
    bus.araddr = 4'h0; bus.arvalid = 1'b1; bus.rready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.arready) begin seen = 1'b1; break; end
    end
    check_eq("bp_r1_accept", 32'(seen), 32'd1);
    @(negedge clk);
    bus.araddr = 4'h4;
    for (int n = 0; n < 10; n++) begin
      check_eq("bp_rvalid_hold", 32'({bus.rvalid, bus.arready}), 32'b10);
      check_eq("bp_rdata_hold", bus.rdata, 32'h0101FFFF);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    check_eq("bp_after_r", 32'({bus.rvalid, bus.arready}), 32'b00);
    @(negedge clk);
    check_eq("bp_r2_accept", 32'(bus.arready), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check_eq("bp_r2_rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("bp_r2_data", bus.rdata, 32'hABCD0001);
    @(negedge clk);

    axi_write(4'h0, 32'h76543210, 4'hF);
    axi_write(4'h4, 32'h00000101, 4'hF);
    axi_write(4'h8, 32'h00000000, 4'hF);
    sync_digit0();
    for (int d = 0; d < 8; d++) begin
      exp_an = ~(8'h01 << d);
      check_eq($sformatf("scan_an_%0d", d), 32'(an), 32'(exp_an));
      check_eq($sformatf("scan_seg_%0d", d), 32'(seg), 32'(hex_tbl[d]));
      check_eq($sformatf("scan_dp_%0d", d), 32'(dp), (d == 0) ? 32'd0 : 32'd1);
      repeat (4) @(negedge clk);
    end
    check_eq("scan_wrap_an", 32'(an), 32'hFE);
    check_eq("scan_wrap_seg", 32'(seg), 32'h40);

    axi_write(4'h8, 32'h00000002, 4'hF);
    sync_digit0();
    repeat (4) @(negedge clk);
    check_eq("blank1_an", 32'(an), 32'hFF);
    check_eq("blank1_seg", 32'(seg), 32'h7F);
    check_eq("blank1_dp", 32'(dp), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("blank_next_an", 32'(an), 32'hFB);
    check_eq("blank_next_seg", 32'(seg), 32'h24);

    axi_write(4'h4, 32'h00000000, 4'hF);
    repeat (2) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      check_eq("disable_an", 32'(an), 32'hFF);
      repeat (4) @(negedge clk);
    end

    // Async reset while BVALID is outstanding.
    axi_write(4'h4, 32'h00000001, 4'hF);
    axi_write(4'h8, 32'h00000000, 4'hF);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_an_active", 32'(an == 8'hFF), 32'd0);
    bus.awaddr = 4'hC; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.awready) begin seen = 1'b1; break; end
    end
    check_eq("ar_w_accept", 32'(seen), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("ar_bvalid_pre", 32'(bus.bvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_bvalid", 32'(bus.bvalid), 32'd0);
    check_eq("ar_an", 32'(an), 32'hFF);
    check_eq("ar_seg", 32'(seg), 32'h7F);
    check_eq("ar_dp", 32'(dp), 32'd1);
    bus.bready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_eq("ar_no_bvalid", 32'({bus.bvalid, bus.rvalid}), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(loop_addr[i]), rd);
      check_eq($sformatf("ar_reg_%0d", i), rd, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
